// File: rtl/alu_rr_scheduler_if.sv
// Request/grant/response bundle between four requesters and the shared-ALU scheduler.
// The scheduler uses the slave modport; the requester side (or a bench) uses master.
interface alu_rr_scheduler_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] alu_sel;
    logic       alu_start;
    logic       alu_busy;
    logic       resp_valid;
    logic [1:0] resp_id;

    modport master (
        output req,
        input  gnt, alu_sel, alu_start, alu_busy, resp_valid, resp_id
    );

    modport slave (
        input  req,
        output gnt, alu_sel, alu_start, alu_busy, resp_valid, resp_id
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Shares one fixed-latency ALU between four requesters: grant -> start -> latency -> result valid.
// Define ALU_SCHED_FIXED_PRIO_EN for fixed priority (req[0] highest); default is round robin.
module alu_rr_scheduler #(
    parameter int unsigned ALU_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    alu_rr_scheduler_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             start_q, start_d;
    logic             busy_q, busy_d;
    logic             valid_q, valid_d;
    logic [1:0]       winner;

`ifdef ALU_SCHED_FIXED_PRIO_EN
    // Scan from lowest priority upward so the lowest asserted index ends up winning.
    always_comb begin
        winner = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[i]) winner = 2'(i);
        end
    end
`else
    logic [1:0] ptr_q, ptr_d;
    logic       rr_found;

    always_comb begin
        winner   = ptr_q;
        rr_found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!rr_found && bus.req[ptr_q + 2'(i)]) begin
                winner   = ptr_q + 2'(i);
                rr_found = 1'b1;
            end
        end
    end

    // The pointer only moves once an operation has actually completed.
    assign ptr_d = (state_q == DONE) ? sel_q + 2'd1 : ptr_q;

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 2'd0;
        else     ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                gnt_d  = 4'b0000;
                sel_d  = 2'd0;
                busy_d = 1'b0;
                if (|bus.req) begin
                    state_d = RUN;
                    gnt_d   = 4'b0001 << winner;
                    sel_d   = winner;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_W'(ALU_LAT - 1);
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
                sel_d   = 2'd0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.alu_sel    = sel_q;
    assign bus.alu_start  = start_q;
    assign bus.alu_busy   = busy_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_id    = sel_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler: expected winners are queued when requests are
// driven and popped by a monitor on every resp_valid; handshake timing is checked per cycle.
module tb_alu_rr_scheduler;
    localparam int unsigned ALU_LAT = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_rr_scheduler_if bus ();

    alu_rr_scheduler #(.ALU_LAT(ALU_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [1:0] sb_q[$];
    logic [1:0] mdl_ptr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},        bus.gnt,        0);
        check({tag, "_alu_sel"},    bus.alu_sel,    0);
        check({tag, "_alu_start"},  bus.alu_start,  0);
        check({tag, "_alu_busy"},   bus.alu_busy,   0);
        check({tag, "_resp_valid"}, bus.resp_valid, 0);
        check({tag, "_resp_id"},    bus.resp_id,    0);
    endtask

    function automatic logic [1:0] exp_winner(input logic [3:0] r);
        logic [1:0] w;
        w = 2'd0;
`ifdef ALU_SCHED_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) if (r[i]) w = 2'(i);
`else
        for (int i = 3; i >= 0; i--) if (r[mdl_ptr + 2'(i)]) w = mdl_ptr + 2'(i);
`endif
        return w;
    endfunction

    // Scoreboard consumer: every resp_valid must match the oldest queued winner.
    always @(negedge clk) begin
        if (bus.resp_valid === 1'b1) begin
            if (sb_q.size() == 0) check("resp_unexpected", bus.resp_valid, 0);
            else                  check("resp_id", bus.resp_id, sb_q.pop_front());
        end
    end

    // Called at a negedge while the DUT sits in IDLE; returns at the negedge of the following IDLE.
    task automatic run_op(input logic [3:0] r, input int drop_at, output int resp_cyc);
        logic [1:0] w;
        w = exp_winner(r);
        bus.req = r;
        sb_q.push_back(w);
        for (int k = 0; k < int'(ALU_LAT); k++) begin
            @(negedge clk);
            check("run_gnt",        bus.gnt,        32'(4'b0001 << w));
            check("run_alu_sel",    bus.alu_sel,    w);
            check("run_alu_start",  bus.alu_start,  (k == 0) ? 1 : 0);
            check("run_alu_busy",   bus.alu_busy,   1);
            check("run_resp_valid", bus.resp_valid, 0);
            if (k == drop_at) bus.req = 4'b0000;
        end
        @(negedge clk);
        check("done_resp_valid", bus.resp_valid, 1);
        check("done_alu_start",  bus.alu_start,  0);
        check("done_alu_busy",   bus.alu_busy,   1);
        check("done_gnt",        bus.gnt,        32'(4'b0001 << w));
        resp_cyc = cyc;
        mdl_ptr  = w + 2'd1;
        @(negedge clk);
        check("idle_gnt",        bus.gnt,        0);
        check("idle_alu_busy",   bus.alu_busy,   0);
        check("idle_resp_valid", bus.resp_valid, 0);
        check("idle_alu_sel",    bus.alu_sel,    0);
    endtask

    initial begin
        int c, prev;
        rst     = 1'b1;
        bus.req = 4'hF;
        mdl_ptr = 2'd0;

        // Reset held with all requests asserted.
        repeat (2) begin
            @(negedge clk);
            check_all_zero("reset");
        end
        rst = 1'b0;

        // Fairness from a fresh reset: 0,1,2,3,0 with fixed spacing between results.
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            run_op(4'hF, -1, c);
            if (i > 0) check("resp_spacing", c - prev, ALU_LAT + 2);
            prev = c;
        end

        // Single requester.
        run_op(4'b0100, -1, c);

        // Two requesters held: alternates in round robin, always 0 under fixed priority.
        repeat (3) run_op(4'b1001, -1, c);

        // Request dropped in the second RUN cycle still completes.
        run_op(4'b0010, 1, c);

        // Reset in the first RUN cycle aborts with no result and clears the pointer.
        bus.req = 4'b0100;
        @(negedge clk);
        check("abort_alu_start", bus.alu_start, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        rst     = 1'b0;
        bus.req = 4'b0000;
        mdl_ptr = 2'd0;
        repeat (ALU_LAT + 2) begin
            @(negedge clk);
            check("post_abort_gnt", bus.gnt, 0);
        end
        run_op(4'hF, -1, c);

        bus.req = 4'b0000;
        repeat (3) @(negedge clk);
        check("quiet_busy", bus.alu_busy, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
